// File: rtl/jtcps_obj_linebuf.sv
// Double-buffered object line buffer: the drawer fills bank ~vlsb while bank vlsb is scanned out
// and erased behind the read, with selectable sprite priority and a post-reset clear sweep.
module jtcps_obj_linebuf #(
  parameter int unsigned DW       = 9,
  parameter int unsigned AW       = 9,
  parameter logic [3:0]  TRANSP   = 4'hF,
  parameter bit          PRIO_1ST = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pxl_cen,
  input  logic          flip,
  input  logic          vlsb,
  input  logic [AW-1:0] hdump,
  input  logic [AW-1:0] buf_addr,
  input  logic [DW-1:0] buf_data,
  input  logic          buf_wr,
  output logic          ready,
  output logic [DW-1:0] pxl
);

  localparam int unsigned Depth = 2 ** AW;
  localparam logic [DW-1:0] Blank = '1;

  typedef enum logic {StClear, StRun} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_q, clr_d;

  logic [DW-1:0] mem0 [Depth];
  logic [DW-1:0] mem1 [Depth];

  // Write pipe, stage S1
  logic          s1_vld_q;
  logic [AW-1:0] s1_addr_q;
  logic [DW-1:0] s1_data_q;
  logic          s1_bank_q;
  logic [3:0]    s1_old_q;

  // Read/erase pipe
  logic          rd_vld_q;
  logic [AW-1:0] raddr_q;
  logic          rbank_q;
  logic [DW-1:0] pxl_q;

  logic          run;
  logic          clearing;
  logic          s1_we;
  logic          cap;
  logic          cap_bank;
  logic [3:0]    old_ram;
  logic [3:0]    old_d;
  logic [1:0]    wa_en;
  logic [AW-1:0] wa_addr;
  logic [DW-1:0] wa_data;
  logic [1:0]    wb_en;
  logic [DW-1:0] rd_word;

  // Clear sweep FSM
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    if (state_q == StClear) begin
      clr_d = clr_q + 1'b1;
      if (clr_q == '1) state_d = StRun;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StClear;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  assign run      = (state_q == StRun);
  assign clearing = (state_q == StClear);

  // Port A: clear sweep hits both banks, otherwise the S1 write goes to its latched bank
  always_comb begin
    s1_we   = s1_vld_q && (!PRIO_1ST || (s1_old_q == TRANSP));
    wa_addr = clearing ? clr_q : s1_addr_q;
    wa_data = clearing ? Blank : s1_data_q;
    wa_en   = 2'b00;
    if (clearing) begin
      wa_en = 2'b11;
    end else if (s1_we) begin
      wa_en[s1_bank_q] = 1'b1;
    end
    wb_en = 2'b00;
    if (rd_vld_q) wb_en[rbank_q] = 1'b1;
  end

  // S0 capture; the old nibble is forwarded from writes landing on the same edge
  always_comb begin
    cap      = run && buf_wr && (buf_data[3:0] != TRANSP);
    cap_bank = ~vlsb;
    old_ram  = cap_bank ? mem1[buf_addr][3:0] : mem0[buf_addr][3:0];
    old_d    = old_ram;
    if (rd_vld_q && (rbank_q == cap_bank) && (raddr_q == buf_addr)) begin
      old_d = Blank[3:0];
    end else if (s1_we && (s1_bank_q == cap_bank) && (s1_addr_q == buf_addr)) begin
      old_d = s1_data_q[3:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_addr_q <= '0;
      s1_data_q <= '0;
      s1_bank_q <= 1'b0;
      s1_old_q  <= '0;
    end else begin
      s1_vld_q <= cap;
      if (cap) begin
        s1_addr_q <= buf_addr;
        s1_data_q <= buf_data;
        s1_bank_q <= cap_bank;
        s1_old_q  <= old_d;
      end
    end
  end

  assign rd_word = rbank_q ? mem1[raddr_q] : mem0[raddr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q <= 1'b0;
      raddr_q  <= '0;
      rbank_q  <= 1'b0;
      pxl_q    <= Blank;
    end else begin
      rd_vld_q <= run && pxl_cen;
      if (pxl_cen) begin
        raddr_q <= flip ? ~hdump : hdump;
        rbank_q <= vlsb;
      end
      if (rd_vld_q) pxl_q <= rd_word;
    end
  end

  // Erase is placed after the drawer port so it wins on a same-address clash
  always_ff @(posedge clk) begin
    if (wa_en[0]) mem0[wa_addr] <= wa_data;
    if (wb_en[0]) mem0[raddr_q] <= Blank;
    if (wa_en[1]) mem1[wa_addr] <= wa_data;
    if (wb_en[1]) mem1[raddr_q] <= Blank;
  end

  assign ready = run;
  assign pxl   = pxl_q;

endmodule
